if_id_fifo: RTL and testbench

IF_ID_FIFO -- requirements
Module: if_id_fifo

---
 rtl/if_id_fifo_pkg.sv | 17 +
 rtl/if_id_fifo_sync_fifo.sv | 64 ++++++
 rtl/if_id_fifo.sv | 84 ++++++++
 tb/tb_if_id_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_fifo_pkg.sv
// Shared fetch/decode constants for the IF/ID buffer.
// Covers the register-bus width, the NOP encoding, the zero word and the irq_o bit layout.
package if_id_fifo_pkg;

    localparam int REG_BUS = 32;

    localparam logic [REG_BUS-1:0] NOP_INST  = 32'h0000_0013;
    localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

    // Bit positions inside irq_o = {debug, plic_any, timer, swi}
    localparam int IRQ_W     = 4;
    localparam int IRQ_DEBUG = 3;
    localparam int IRQ_PLIC  = 2;
    localparam int IRQ_TIMER = 1;
    localparam int IRQ_SWI   = 0;

endpackage

// File: rtl/if_id_fifo_sync_fifo.sv
// Single-clock FIFO with wrapping pointers, an occupancy counter and a synchronous clear.
// Storage is not reset; it is only meaningful where the counter says it is occupied.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/if_id_fifo.sv
// IF/ID pipeline buffer: a small FIFO of {inst, addr} between fetch and decode.
// Presents a NOP when empty and registers the interrupt request vector alongside.
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int               XLEN   = REG_BUS,
    parameter int               DEPTH  = 2,
    parameter int               PLIC_N = 4,
    parameter logic [XLEN-1:0]  NOP    = NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          inst_i,
    input  logic [XLEN-1:0]          addr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          inst_o,
    output logic [XLEN-1:0]          addr_o,
    input  logic                     debug_irq_i,
    input  logic                     timer_irq_i,
    input  logic                     swi_irq_i,
    input  logic [PLIC_N-1:0]        plic_irq_i,
    output logic [IRQ_W-1:0]         irq_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int ENTRY_W = 2 * XLEN;

    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [IRQ_W-1:0]   irq_next;

    assign wdata = {inst_i, addr_i};

    // Readiness depends only on occupancy and flush, never on out_ready_i
    assign in_ready_o  = !full && !flush_i;
    assign out_valid_o = !empty;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level_o),
        .full  (full),
        .empty (empty)
    );

    assign inst_o = out_valid_o ? rdata[ENTRY_W-1:XLEN] : NOP;
    assign addr_o = out_valid_o ? rdata[XLEN-1:0]       : XLEN'(ZERO_WORD);

    always_comb begin
        irq_next            = '0;
        irq_next[IRQ_DEBUG] = debug_irq_i;
        irq_next[IRQ_PLIC]  = |plic_irq_i;
        irq_next[IRQ_TIMER] = timer_irq_i;
        irq_next[IRQ_SWI]   = swi_irq_i;
    end

    // A flush drops any pending request along with the buffered instructions
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            irq_o <= '0;
        end else begin
            irq_o <= irq_next;
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Randomized bench for if_id_fifo against a queue-based model, plus directed literal checks.
module tb_if_id_fifo;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] addr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] addr_o;
    logic        debug_irq_i = 1'b0;
    logic        timer_irq_i = 1'b0;
    logic        swi_irq_i = 1'b0;
    logic [3:0]  plic_irq_i = '0;
    logic [3:0]  irq_o;
    logic [1:0]  level_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] model_q[$];
    logic [3:0]  model_irq = '0;
    bit          model_armed = 1'b0;
    bit          model_push;
    bit          model_pop;

    always #5 clk = ~clk;

    if_id_fifo #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .PLIC_N (4),
        .NOP    (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .addr_i      (addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .addr_o      (addr_o),
        .debug_irq_i (debug_irq_i),
        .timer_irq_i (timer_irq_i),
        .swi_irq_i   (swi_irq_i),
        .plic_irq_i  (plic_irq_i),
        .irq_o       (irq_o),
        .level_o     (level_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge
    task automatic applyStimulus(input logic r, input logic fl, input logic v,
                                 input logic [31:0] inst, input logic [31:0] addr,
                                 input logic ordy, input logic dbg, input logic tmr,
                                 input logic swi, input logic [3:0] plic);
        rst         = r;
        flush_i     = fl;
        in_valid_i  = v;
        inst_i      = inst;
        addr_i      = addr;
        out_ready_i = ordy;
        debug_irq_i = dbg;
        timer_irq_i = tmr;
        swi_irq_i   = swi;
        plic_irq_i  = plic;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of accepted entries, updated at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            model_irq   = '0;
            model_armed = 1'b1;
        end else if (flush_i) begin
            model_q.delete();
            model_irq = '0;
        end else begin
            model_irq  = {debug_irq_i, |plic_irq_i, timer_irq_i, swi_irq_i};
            model_pop  = (model_q.size() != 0) && out_ready_i;
            model_push = in_valid_i && (model_q.size() < DEPTH);
            if (model_pop) void'(model_q.pop_front());
            if (model_push) model_q.push_back({inst_i, addr_i});
        end
    end

    always @(negedge clk) begin
        if (model_armed) begin
            checkOutput("out_valid", 64'(out_valid_o), 64'(model_q.size() != 0));
            checkOutput("level", 64'(level_o), 64'(model_q.size()));
            checkOutput("in_ready", 64'(in_ready_o), 64'((model_q.size() < DEPTH) && !flush_i));
            checkOutput("inst", 64'(inst_o), (model_q.size() != 0) ? 64'(model_q[0][63:32]) : 64'h13);
            checkOutput("addr", 64'(addr_o), (model_q.size() != 0) ? 64'(model_q[0][31:0]) : 64'h0);
            checkOutput("irq", 64'(irq_o), 64'(model_irq));
        end
    end

    initial begin
        // Reset held two cycles with fetch data offered
        applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 32'h100, 0, 0, 0, 0, 4'h0);
        applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 32'h100, 0, 0, 0, 0, 4'h0);
        checkOutput("rst_out_valid", 64'(out_valid_o), 64'h0);
        checkOutput("rst_inst", 64'(inst_o), 64'h13);
        checkOutput("rst_addr", 64'(addr_o), 64'h0);
        checkOutput("rst_level", 64'(level_o), 64'h0);
        checkOutput("rst_irq", 64'(irq_o), 64'h0);
        checkOutput("rst_in_ready", 64'(in_ready_o), 64'h1);

        // Fill to full with decode stalled
        applyStimulus(0, 0, 1, 32'h00A0_0093, 32'h0, 0, 0, 0, 0, 4'h0);
        checkOutput("fill1_level", 64'(level_o), 64'h1);
        applyStimulus(0, 0, 1, 32'h0010_0113, 32'h4, 0, 0, 0, 0, 4'h0);
        checkOutput("full_level", 64'(level_o), 64'h2);
        checkOutput("full_in_ready", 64'(in_ready_o), 64'h0);
        checkOutput("full_inst", 64'(inst_o), 64'h00A0_0093);
        checkOutput("full_addr", 64'(addr_o), 64'h0);

        // Flush while full, with a push offered in the same cycle
        applyStimulus(0, 1, 1, 32'h0000_0513, 32'h40, 0, 0, 0, 0, 4'h0);
        checkOutput("flush_level", 64'(level_o), 64'h0);
        checkOutput("flush_inst", 64'(inst_o), 64'h13);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0);
        checkOutput("flush_push_absent", 64'(out_valid_o), 64'h0);

        // Simultaneous push and pop at level 1
        applyStimulus(0, 0, 1, 32'h0040_0013, 32'h4, 0, 0, 0, 0, 4'h0);
        checkOutput("pp_pre_addr", 64'(addr_o), 64'h4);
        applyStimulus(0, 0, 1, 32'h0080_0013, 32'h8, 1, 0, 0, 0, 4'h0);
        checkOutput("pp_level", 64'(level_o), 64'h1);
        checkOutput("pp_addr", 64'(addr_o), 64'h8);
        checkOutput("pp_inst", 64'(inst_o), 64'h0080_0013);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 4'h0);
        checkOutput("drain_level", 64'(level_o), 64'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 4'h0);
        checkOutput("pop_empty_level", 64'(level_o), 64'h0);

        // Interrupt vector, then the same request under flush
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 4'b0100);
        checkOutput("irq_plic_timer", 64'(irq_o), 64'h6);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 0, 0, 1, 0, 4'b0100);
        checkOutput("irq_flush", 64'(irq_o), 64'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1, 4'b0000);
        checkOutput("irq_debug_swi", 64'(irq_o), 64'h9);

        // Back-to-back stream across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 32'h1000 + 32'(i), 32'(4 * i), 1, 0, 0, 0, 4'h0);
            checkOutput("wrap_valid", 64'(out_valid_o), 64'h1);
            checkOutput("wrap_addr", 64'(addr_o), 64'(4 * i));
            checkOutput("wrap_level", 64'(level_o), 64'h1);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 4'h0);
        checkOutput("wrap_end_level", 64'(level_o), 64'h0);

        // Randomized traffic, including occasional reset and flush
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom, $urandom,
                          $urandom_range(0, 2) == 0,
                          1'($urandom), 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
